seq_right_shifter: RTL
======================

Name: seq_right_shifter

Overview:
- Iterative right shifter: shifts one bit per clock, performing SRL (logical) or SRA (arithmetic) by a variable amount.
- Complements the combinational left shifter in the non-pipelined RISC-V datapath.
- The execute stage uses it for SRL/SRLI/SRA/SRAI: it issues a start pulse, holds off the PC update while busy, and captures the result on done.

Parameters:
- Bus_size, 32, datapath width in bits; power of two, at least 4.
- Shamt_size, $clog2(Bus_size), width of the shift-amount operand (5 for RV32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- arith  input  1  1 = SRA (sign fill), 0 = SRL (zero fill); sampled with start.
- shift_in  input  Bus_size  operand; sampled with start.
- shamt  input  Shamt_size  shift amount, 0..Bus_size-1; sampled with start.
- shift_out  output  Bus_size  registered result; holds the last completed result.
- busy  output  1  high while an operation is in progress (state != IDLE).
- done  output  1  one-cycle completion pulse; shift_out is valid while it is high.

Behaviour:
- Reset: applies on any rising edge with rst=1, in every state including mid-operation.
  - State goes to IDLE.
  - shift_out, busy and done go to 0.
  - Working register, count register and fill-mode register go to 0.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered or decoded from state only; nothing passes combinationally from input to output.
- IDLE:
  - start=1 at an edge latches shift_in into the working register, shamt into the count register and arith into the fill-mode register.
  - Next state is SHIFT if shamt != 0.
  - If shamt == 0, next state is DONE and shift_out <= shift_in at the same edge.
- SHIFT, at each edge:
  - work <= {fill, work[Bus_size-1:1]}, with fill = arith_q ? work[Bus_size-1] : 1'b0.
  - count <= count - 1.
  - When count == 1 at the edge, this is the final shift: shift_out <= the shifted value and next state is DONE.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE. start is ignored in DONE.
- Latency: counting the edge that samples start as edge 1, done is visible after edge shamt+1.
  - busy is high from after edge 1 through the done cycle.
  - Back-to-back issue: a new start is accepted at the edge leaving DONE+1, i.e. the first IDLE cycle.
- start while busy (SHIFT or DONE): ignored. The latched operands are unaffected, and the input operands may change freely.
- shift_out changes only on entry to DONE or on reset. Intermediate working values never appear on shift_out.
- shamt == Bus_size-1 is the maximum: Bus_size-1 shift cycles. The count never wraps because it is checked against 1 before decrementing.
- The fill bit for SRA is taken from the current MSB each cycle. This is equivalent to the original sign bit because the MSB is replicated.
- Reset asserted in the same cycle as start: reset wins and the operation is not accepted.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 and shift_in=32'hFFFF_FFFF -> shift_out=0, busy=0, done=0; no operation starts after rst drops.
- SRL: shift_in=32'h8000_00F0, shamt=4, arith=0 -> done pulses after edge 5, shift_out=32'h0800_000F, busy high for 5 cycles, done high for exactly 1.
- SRA: same operands with arith=1 -> shift_out=32'hF800_000F; then shift_in=32'h7000_0000, shamt=4, arith=1 -> shift_out=32'h0700_0000 (positive operand, zero fill).
- Boundaries:
  - shamt=0 with shift_in=32'h1234_5678 -> done after edge 1, shift_out=32'h1234_5678.
  - shamt=31 with shift_in=32'h8000_0000 -> SRA gives 32'hFFFF_FFFF and SRL gives 32'h0000_0001, each with done after edge 32.
- Busy protection: start SRL 32'h0000_0100 by 8, then pulse start with shift_in=32'hDEAD_BEEF, shamt=1 during SHIFT -> result is 32'h0000_0001 and no second done occurs.
- Reset mid-operation: assert rst at the 3rd SHIFT cycle of a shamt=10 op -> next cycle has busy=0, done=0, shift_out=0, and done never pulses for that op; a following SRA 32'hF000_0000 by 2 returns 32'hFC00_0000.

Source files
------------

// File: rtl/seq_right_shifter.sv
// Iterative right shifter: one bit position per clock, logical (SRL) or
// arithmetic (SRA) fill, variable shift amount. Used by the execute stage
// for SRL/SRLI/SRA/SRAI; the stage stalls on busy and captures on done.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; operands latched on the accepting edge
//   SHIFT | shifting one bit per cycle until the count reaches 1
//   DONE  | one-cycle completion pulse, shift_out holds the result
//
module seq_right_shifter #(
    parameter int Bus_size   = 32,
    parameter int Shamt_size = $clog2(Bus_size)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  arith,
    input  logic [Bus_size-1:0]   shift_in,
    input  logic [Shamt_size-1:0] shamt,
    output logic [Bus_size-1:0]   shift_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [Shamt_size-1:0] CountZero = '0;
    localparam logic [Shamt_size-1:0] CountOne  = {{(Shamt_size-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [Bus_size-1:0]     work;
    logic [Shamt_size-1:0]   count;
    logic                    arith_q;
    logic                    fill;
    logic [Bus_size-1:0]     work_shifted;

    // Next working value: one position right, MSB replicated for SRA.
    // Replicating the current MSB each step equals filling with the
    // original sign bit, since that bit is what the MSB keeps holding.
    always_comb begin
        fill         = arith_q ? work[Bus_size-1] : 1'b0;
        work_shifted = {fill, work[Bus_size-1:1]};
    end

    // Control FSM and datapath registers; shift_out only updates on entry
    // to DONE so intermediate working values are never exposed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            count     <= '0;
            arith_q   <= 1'b0;
            shift_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work    <= shift_in;
                        count   <= shamt;
                        arith_q <= arith;
                        if (shamt == CountZero) begin
                            shift_out <= shift_in;
                            state     <= DONE;
                        end else begin
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work  <= work_shifted;
                    count <= count - CountOne;
                    // Checked before decrementing, so count never wraps.
                    if (count == CountOne) begin
                        shift_out <= work_shifted;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status decoded from state only; no input reaches an output combinationally.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule
